// File: rtl/rr_arbiter_pkg.sv
// Shared types and default parameters for the round-robin arbiter.
// Imported by the arbiter top and its testbench.
package rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_HW       = 5;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesting masters and the arbiter.
// gnt_id also steers the shared datapath select mux.
interface rr_arbiter_if #(
    parameter int N   = 8,
    parameter int IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;

    modport master (output req, done, input gnt, gnt_id, gnt_valid);
    modport slave  (input req, done, output gnt, gnt_id, gnt_valid);
endinterface

// File: rtl/rr_pri_enc.sv
// Fixed-priority encoder: the lowest set bit of vec_i wins.
// idx_o is 0 when no bit is set; valid_o flags a winner.
module rr_pri_enc #(
    parameter int W  = 16,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // NOTE: idx_o gets a default before the loop so every path assigns it and no latch is inferred.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IW'(i);
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating pointer ahead of a fixed-priority encoder,
// registered one-hot grant held until release by the owner or hold timeout.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HW       = DEF_HW,
    parameter int IDW      = $clog2(N)
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter_if.slave bus
);

    localparam int EW = $clog2(2 * N);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_e         state_q;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_cnt_q;
    logic [N-1:0]   gnt_q;
    logic [IDW-1:0] gnt_id_q;
    logic           gnt_valid_q;

    logic           hold_hit;
    logic           rel;
    logic [2*N-1:0] dbl_req;
    logic [2*N-1:0] masked_req;
    logic [EW-1:0]  enc_idx;
    logic           enc_valid;
    logic [IDW-1:0] win_id;
    logic [N-1:0]   win_gnt;

    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign rel      = (state_q == ST_GRANT) &&
                      (!bus.req[gnt_id_q] || bus.done || hold_hit);

    // On release the owner drops to lowest priority and the same cycle's arbitration already sees it.
    assign ptr_d = rel ? ((gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1) : ptr_q;

    assign dbl_req = {bus.req, bus.req};

    always_comb begin
        masked_req = '0;
        for (int j = 0; j < 2 * N; j++) begin
            masked_req[j] = dbl_req[j] && (j >= int'(ptr_d));
        end
    end

    rr_pri_enc #(.W(2 * N), .IW(EW)) u_pri_enc (
        .vec_i   (masked_req),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign win_id  = (enc_idx >= EW'(N)) ? IDW'(enc_idx - EW'(N)) : IDW'(enc_idx);
    assign win_gnt = N'(1) << win_id;

    // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state_q     <= ST_GRANT;
                        gnt_q       <= win_gnt;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end
                end
                ST_GRANT: begin
                    if (rel && enc_valid) begin
                        gnt_q       <= win_gnt;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= '0;
                    end else if (rel) begin
                        state_q     <= ST_IDLE;
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        hold_cnt_q  <= '0;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q  <= hold_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=8, MAX_HOLD=4) with a queue-free search model
// compared on every cycle plus hand-computed literal expectations.
module tb_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arbiter_if #(.N(N)) bus ();

    rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .HW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: owner index (-1 = idle), pointer, cycles held so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_age   = 0;

    function automatic int search(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_age   <= 0;
        end else if (m_owner < 0) begin
            if (bus.req != '0) begin
                m_owner <= search(bus.req, m_ptr);
                m_age   <= 1;
            end
        end else if (!bus.req[m_owner] || bus.done || m_age == MAX_HOLD) begin
            m_ptr   <= (m_owner + 1) % N;
            m_owner <= search(bus.req, (m_owner + 1) % N);
            m_age   <= 1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    function automatic logic [31:0] exp_gnt();
        return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_gnt",       32'(bus.gnt),       exp_gnt());
            check("model_gnt_id",    32'(bus.gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
            check("model_gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        #2 rst = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req  = '0;
        bus.done = 1'b0;
        tick(2);
        rst    = 1'b0;
        cmp_en = 1'b1;
        check("reset_gnt_valid", 32'(bus.gnt_valid), 32'd0);

        // Two requesters: 4 wins from ptr 0, then 6 with no bubble.
        bus.req = 8'b0101_0000;
        tick();
        check("t2_gnt", 32'(bus.gnt), 32'h10);
        check("t2_gnt_id", 32'(bus.gnt_id), 32'd4);
        bus.req = 8'b0100_0000;
        tick();
        check("t2_next_id", 32'(bus.gnt_id), 32'd6);
        check("t2_no_gap", 32'(bus.gnt_valid), 32'd1);
        bus.req = '0;
        tick();
        check("t2_idle", 32'(bus.gnt_valid), 32'd0);

        // done while idle is ignored.
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("idle_done", 32'(bus.gnt_valid), 32'd0);

        // One-cycle pulse on bit 3 from ptr 7: exactly one grant cycle, then ptr=4.
        bus.req = 8'h08;
        tick();
        check("t6_gnt", 32'(bus.gnt), 32'h08);
        bus.req = '0;
        tick();
        check("t6_idle", 32'(bus.gnt), 32'h00);
        bus.req = 8'h18;
        tick();
        check("t6_ptr4", 32'(bus.gnt_id), 32'd4);
        bus.req = '0;
        tick();

        // Reset asserted mid-grant clears outputs immediately.
        bus.req = 8'hFF;
        tick();
        check("t1_pre_valid", 32'(bus.gnt_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_gnt", 32'(bus.gnt), 32'h00);
        check("t1_gnt_id", 32'(bus.gnt_id), 32'd0);
        check("t1_gnt_valid", 32'(bus.gnt_valid), 32'd0);
        bus.req = '0;
        tick(2);
        rst = 1'b0;

        // done on the 2nd grant cycle hands over to 7, then back to 0.
        bus.req = 8'b1000_0001;
        tick();
        check("t4_first", 32'(bus.gnt_id), 32'd0);
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        check("t4_after_done", 32'(bus.gnt_id), 32'd7);
        bus.req = 8'b0000_0001;
        tick();
        check("t4_regrant", 32'(bus.gnt_id), 32'd0);
        bus.req = '0;
        tick();

        // Sole requester held: continuous grant across timeouts.
        bus.req = 8'b0000_0100;
        for (int c = 0; c < 13; c++) begin
            tick();
            check("t5_id", 32'(bus.gnt_id), 32'd2);
            check("t5_valid", 32'(bus.gnt_valid), 32'd1);
        end
        bus.req = '0;
        tick();

        // All requesting from ptr 0: 4-cycle grants walking 0..7,0.
        do_reset();
        bus.req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick();
                check("t3_id", 32'(bus.gnt_id), 32'(g % N));
                check("t3_gnt", 32'(bus.gnt), 32'd1 << (g % N));
            end
        end
        bus.req = '0;
        tick(3);
        check("final_idle", 32'(bus.gnt_valid), 32'd0);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
